// File: rtl/apu_pkg.sv
// apu_pkg: shared APU constants for the channel 1 frequency datapath
package apu_pkg;
  localparam int FREQ_W = 11;
  localparam logic [FREQ_W-1:0] FREQ_MAX = 11'h7FF;
endpackage

// File: rtl/ch1_freq_counter.sv
// ch1_freq_counter: reloadable period up-counter with a registered wrap pulse
module ch1_freq_counter
  import apu_pkg::*;
(
  input  logic              clk,
  input  logic              napu_reset,
  input  logic              reload,
  input  logic              tick,
  input  logic [FREQ_W-1:0] load_val,
  output logic              wrap
);
  logic [FREQ_W-1:0] cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  // reload beats a wrapping tick and suppresses its pulse
  always_comb begin
    wrap_d = !reload && tick && cnt_q == FREQ_MAX;
    cnt_d  = (reload || wrap_d) ? load_val : tick ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign wrap = wrap_q;
endmodule

// File: rtl/ch1_sweep_freq.sv
// ch1_sweep_freq: channel 1 frequency register, sweep shadow/adder, overflow latch and period tick
module ch1_sweep_freq
  import apu_pkg::*;
(
  input  logic              clk,
  input  logic              napu_reset,
  input  logic              apu_wr,
  input  logic              ff13,
  input  logic              ff14,
  input  logic [7:0]        d,
  input  logic              sweep_neg,
  input  logic              tick_1mhz,
  input  logic              ch1_restart,
  input  logic              ch1_ld_shift,
  input  logic              ch1_shift_clk,
  input  logic              ch1_freq_upd1,
  input  logic              ch1_freq_upd2,
  output logic [FREQ_W-1:0] freq,
  output logic              atys,
  output logic              copu
);
  logic [FREQ_W-1:0] freq_q, freq_d, shadow_q, shadow_d, base;
  logic [FREQ_W:0]   sum;
  logic              ovf_q, ovf_d, carry;
  // subtraction never borrows while shadow <= freq, so only the add carry matters
  always_comb begin
    sum      = sweep_neg ? {1'b0, freq_q} - {1'b0, shadow_q} : {1'b0, freq_q} + {1'b0, shadow_q};
    carry    = !sweep_neg && sum[FREQ_W];
    base     = (ch1_freq_upd2 && !carry) ? sum[FREQ_W-1:0] : freq_q;
    freq_d   = {(apu_wr && ff14) ? d[2:0] : base[10:8], (apu_wr && ff13) ? d : base[7:0]};
    shadow_d = ch1_ld_shift ? freq_q : ch1_shift_clk ? shadow_q >> 1 : shadow_q;
    ovf_d    = ch1_restart ? 1'b0 : (ch1_freq_upd1 && carry) ? 1'b1 : ovf_q;
  end
  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      freq_q   <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end
  ch1_freq_counter u_cnt (
    .clk       (clk),
    .napu_reset(napu_reset),
    .reload    (ch1_restart),
    .tick      (tick_1mhz),
    .load_val  (freq_q),
    .wrap      (copu)
  );
  assign freq = freq_q;
  assign atys = !ovf_q;
endmodule

// File: tb/tb_ch1_sweep_freq.sv
// tb_ch1_sweep_freq: directed and random checks against a period/shift-count reference model
module tb_ch1_sweep_freq;
  logic        clk = 1'b0, napu_reset = 1'b0;
  logic        apu_wr = 0, ff13 = 0, ff14 = 0, sweep_neg = 0, tick_1mhz = 0;
  logic        ch1_restart = 0, ch1_ld_shift = 0, ch1_shift_clk = 0, ch1_freq_upd1 = 0, ch1_freq_upd2 = 0;
  logic [7:0]  d = 0;
  logic [10:0] freq;
  logic        atys, copu;
  int total = 0, bad = 0;
  int m_freq = 0, m_src = 0, m_shifts = 0, m_ovf = 0, m_ticks = 0, m_period = 2048, m_copu = 0;
  int sh, sum, nf, n;
  bit carry;

  ch1_sweep_freq dut (
    .clk(clk), .napu_reset(napu_reset), .apu_wr(apu_wr), .ff13(ff13), .ff14(ff14), .d(d),
    .sweep_neg(sweep_neg), .tick_1mhz(tick_1mhz), .ch1_restart(ch1_restart),
    .ch1_ld_shift(ch1_ld_shift), .ch1_shift_clk(ch1_shift_clk),
    .ch1_freq_upd1(ch1_freq_upd1), .ch1_freq_upd2(ch1_freq_upd2),
    .freq(freq), .atys(atys), .copu(copu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: shadow is the loaded frequency shifted by a count, the period is 2048-freq ticks
  initial forever begin
    @(posedge clk or negedge napu_reset);
    if (!napu_reset) begin
      m_freq = 0; m_src = 0; m_shifts = 0; m_ovf = 0; m_ticks = 0; m_period = 2048; m_copu = 0;
    end else begin
      sh = m_src >> m_shifts;
      sum = sweep_neg ? m_freq - sh : m_freq + sh;
      carry = !sweep_neg && sum > 2047;
      nf = (ch1_freq_upd2 && !carry) ? (sum & 'h7FF) : m_freq;
      if (apu_wr && ff13) nf = (nf & 'h700) | int'(d);
      if (apu_wr && ff14) nf = (nf & 'hFF) | ((int'(d) & 7) << 8);
      if (ch1_restart) m_ovf = 0;
      else if (ch1_freq_upd1 && carry) m_ovf = 1;
      m_copu = 0;
      if (ch1_restart) begin
        m_ticks = 0; m_period = 2048 - m_freq;
      end else if (tick_1mhz) begin
        m_ticks++;
        if (m_ticks == m_period) begin
          m_copu = 1; m_ticks = 0; m_period = 2048 - m_freq;
        end
      end
      if (ch1_ld_shift) begin
        m_src = m_freq; m_shifts = 0;
      end else if (ch1_shift_clk && m_shifts < 12) m_shifts++;
      m_freq = nf;
    end
    #1;
    chk("model_freq", int'(freq), m_freq);
    chk("model_atys", int'(atys), m_ovf ? 0 : 1);
    chk("model_copu", int'(copu), m_copu);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    {apu_wr, ff13, ff14, tick_1mhz, ch1_restart, ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2} = '0;
  endtask

  task automatic wr(input bit hi, input logic [7:0] v);
    apu_wr = 1; ff13 = !hi; ff14 = hi; d = v;
    cyc();
  endtask

  task automatic setf(input logic [7:0] hi, input logic [7:0] lo);
    wr(0, lo);
    wr(1, hi);
  endtask

  initial begin
    #11;
    chk("rst_freq", int'(freq), 0);
    chk("rst_atys", int'(atys), 1);
    chk("rst_copu", int'(copu), 0);
    #1 napu_reset = 1;
    // period of two ticks at freq 7FE
    setf(8'h07, 8'hFE);
    ch1_restart = 1; cyc();
    for (int i = 0; i < 6; i++) begin
      tick_1mhz = 1; cyc();
      chk("t1_copu", int'(copu), i % 2);
    end
    // add sweep without overflow
    setf(8'h01, 8'h00);
    chk("t2_freq0", int'(freq), 'h100);
    ch1_ld_shift = 1; cyc();
    ch1_shift_clk = 1; cyc();
    ch1_freq_upd1 = 1; cyc();
    ch1_freq_upd2 = 1; cyc();
    chk("t2_freq", int'(freq), 'h180);
    chk("t2_atys", int'(atys), 1);
    // overflow kills, freq holds, restart revives
    setf(8'h07, 8'h00);
    ch1_ld_shift = 1; cyc();
    ch1_shift_clk = 1; cyc();
    ch1_freq_upd1 = 1; cyc();
    chk("t3_atys_ovf", int'(atys), 0);
    ch1_freq_upd2 = 1; cyc();
    chk("t3_freq_hold", int'(freq), 'h700);
    chk("t3_atys_sticky", int'(atys), 0);
    ch1_restart = 1; cyc();
    chk("t3_atys_restart", int'(atys), 1);
    // subtract sweep
    setf(8'h04, 8'h00);
    ch1_ld_shift = 1; cyc();
    ch1_shift_clk = 1; cyc();
    ch1_shift_clk = 1; cyc();
    sweep_neg = 1; ch1_freq_upd1 = 1; ch1_freq_upd2 = 1; cyc();
    sweep_neg = 0;
    chk("t4_freq", int'(freq), 'h300);
    chk("t4_atys", int'(atys), 1);
    // CPU high-field write merges with the sweep result
    setf(8'h01, 8'h00);
    ch1_ld_shift = 1; cyc();
    ch1_shift_clk = 1; cyc();
    apu_wr = 1; ff14 = 1; d = 8'h05; ch1_freq_upd2 = 1; cyc();
    chk("t5_freq", int'(freq), 'h580);
    // async reset mid-count with overflow and copu active
    setf(8'h07, 8'hF0);
    ch1_restart = 1; cyc();
    ch1_ld_shift = 1; cyc();
    ch1_freq_upd1 = 1; cyc();
    chk("t6_atys_pre", int'(atys), 0);
    for (int i = 0; i < 16; i++) begin
      tick_1mhz = 1; cyc();
    end
    chk("t6_copu_pre", int'(copu), 1);
    #2 napu_reset = 0;
    #1;
    chk("t6_async_freq", int'(freq), 0);
    chk("t6_async_atys", int'(atys), 1);
    chk("t6_async_copu", int'(copu), 0);
    cyc();
    napu_reset = 1;
    // restart beats a wrapping tick
    setf(8'h07, 8'hFE);
    ch1_restart = 1; cyc();
    tick_1mhz = 1; cyc();
    setf(8'h01, 8'h23);
    ch1_restart = 1; tick_1mhz = 1; cyc();
    chk("t6_restart_tick_copu", int'(copu), 0);
    n = 0;
    while (!copu && n < 2100) begin
      tick_1mhz = 1; cyc();
      n++;
    end
    chk("t6_period_after_restart", n, 2048 - 'h123);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      apu_wr = ($urandom_range(0, 15) == 0);
      ff13 = $urandom_range(0, 1); ff14 = $urandom_range(0, 1);
      d = 8'($urandom);
      sweep_neg = $urandom_range(0, 1);
      tick_1mhz = ($urandom_range(0, 3) != 0);
      ch1_restart = ($urandom_range(0, 150) == 0);
      ch1_ld_shift = ($urandom_range(0, 20) == 0);
      ch1_shift_clk = ($urandom_range(0, 6) == 0);
      ch1_freq_upd1 = ($urandom_range(0, 10) == 0);
      ch1_freq_upd2 = ($urandom_range(0, 10) == 0);
      cyc();
      if ($urandom_range(0, 700) == 0) begin
        #2 napu_reset = 0;
        cyc();
        napu_reset = 1;
      end
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
